// File: rtl/m_req_download_pkg.sv
// ---------------------------------------------------------------------------
// m_req_download_pkg
// Definitions shared by the ring download and upload message paths:
//   FLIT_W   - flit width in bits
//   ctrl_e   - flit type encoding carried alongside each flit
//   state_e  - assembler state codes, also exported on fsm_state
// ---------------------------------------------------------------------------
package m_req_download_pkg;

   localparam int FLIT_W = 16;

   typedef enum logic [1:0] {
      CTRL_NONE = 2'b00,
      CTRL_HEAD = 2'b01,
      CTRL_BODY = 2'b10,
      CTRL_TAIL = 2'b11
   } ctrl_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RECV = 2'b01,
      ST_FULL = 2'b10,
      ST_DROP = 2'b11
   } state_e;

endpackage : m_req_download_pkg

// File: rtl/m_req_download_datapath.sv
// ---------------------------------------------------------------------------
// download_datapath
// Flit buffer, flit counter and message packing for the download assembler.
//   clk, rst       - clock, asynchronous active-low reset
//   load_head      - clear buffer, store flit_in at index 0, count = 1
//   store_flit     - store flit_in at index count, count + 1
//   flit_in        - flit to store
//   cnt_full       - count has reached MAX_FLITS
//   msg_*          - buffer contents presented as the assembled message
//   msg_flit_cnt   - number of flits currently stored
// ---------------------------------------------------------------------------
module download_datapath
   import m_req_download_pkg::*;
#(
   parameter int MAX_FLITS = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_head,
   input  logic              store_flit,
   input  logic [FLIT_W-1:0] flit_in,
   output logic              cnt_full,
   output logic [FLIT_W-1:0] msg_head,
   output logic [FLIT_W-1:0] msg_addrhi,
   output logic [FLIT_W-1:0] msg_addrlo,
   output logic [127:0]      msg_data,
   output logic [3:0]        msg_flit_cnt
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_FLITS);

   logic [FLIT_W-1:0] buf_q [MAX_FLITS];
   logic [FLIT_W-1:0] buf_d [MAX_FLITS];
   logic [3:0]        cnt_q;
   logic [3:0]        cnt_d;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (load_head) begin
         for (int i = 0; i < MAX_FLITS; i++) buf_d[i] = '0;
         buf_d[0] = flit_in;
         cnt_d    = 4'd1;
      end else if (store_flit && (cnt_q < MAX_CNT)) begin
         for (int i = 0; i < MAX_FLITS; i++) begin
            if (cnt_q == 4'(i)) buf_d[i] = flit_in;
         end
         cnt_d = cnt_q + 4'd1;
      end
   end

   // NOTE: the buffer is reset explicitly because stale message contents
   // must never be presented after reset; this keeps it in flops, not RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_FLITS; i++) buf_q[i] <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

   assign cnt_full     = (cnt_q == MAX_CNT);
   assign msg_flit_cnt = cnt_q;
   assign msg_head     = buf_q[0];
   assign msg_addrhi   = buf_q[1];
   assign msg_addrlo   = buf_q[2];

   // Data flit k lands in the k-th 16-bit slot counted from the MSB end;
   // slots beyond MAX_FLITS read as zero.
   for (genvar k = 0; k < 8; k++) begin : g_pack
      if (3 + k < MAX_FLITS) begin : g_used
         assign msg_data[127-16*k -: 16] = buf_q[3+k];
      end else begin : g_unused
         assign msg_data[127-16*k -: 16] = '0;
      end
   end

endmodule : download_datapath

// File: rtl/m_req_download.sv
// ---------------------------------------------------------------------------
// m_req_download
// Reassembles ring flits (head, body..., tail) into one message and holds it
// until the consumer reads it.
//   clk, rst          - clock, asynchronous active-low reset
//   v_flit_in, flit_in, ctrl_in, rdy_out - flit input handshake
//   msg_rd_in, v_msg_out, msg_*          - assembled message handshake
//   fsm_state         - current state code
//   err_out           - one-cycle pulse on a protocol error
// ---------------------------------------------------------------------------
module m_req_download
   import m_req_download_pkg::*;
#(
   parameter int MAX_FLITS = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          v_flit_in,
   input  logic [15:0]   flit_in,
   input  logic [1:0]    ctrl_in,
   output logic          rdy_out,
   input  logic          msg_rd_in,
   output logic          v_msg_out,
   output logic [15:0]   msg_head,
   output logic [15:0]   msg_addrhi,
   output logic [15:0]   msg_addrlo,
   output logic [127:0]  msg_data,
   output logic [3:0]    msg_flit_cnt,
   output logic [1:0]    fsm_state,
   output logic          err_out
);

   state_e state_q, state_d;
   logic   err_q, err_d;
   logic   load_head, store_flit, cnt_full, accept;
   ctrl_e  ctrl;

   assign ctrl    = ctrl_e'(ctrl_in);
   assign rdy_out = (state_q != ST_FULL);
   assign accept  = v_flit_in && rdy_out && (ctrl != CTRL_NONE);

   always_comb begin
      state_d    = state_q;
      err_d      = 1'b0;
      load_head  = 1'b0;
      store_flit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (ctrl == CTRL_HEAD) begin
                  load_head = 1'b1;
                  state_d   = ST_RECV;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_RECV: begin
            if (accept) begin
               if (ctrl == CTRL_HEAD) begin
                  // Partial message is abandoned and the new one started.
                  err_d     = 1'b1;
                  load_head = 1'b1;
               end else if (cnt_full) begin
                  // Overlong message: drop the rest, or end here on a tail.
                  err_d   = 1'b1;
                  state_d = (ctrl == CTRL_TAIL) ? ST_IDLE : ST_DROP;
               end else begin
                  store_flit = 1'b1;
                  if (ctrl == CTRL_TAIL) state_d = ST_FULL;
               end
            end
         end
         ST_FULL: begin
            if (msg_rd_in) state_d = ST_IDLE;
         end
         ST_DROP: begin
            if (accept) begin
               if (ctrl == CTRL_HEAD) begin
                  load_head = 1'b1;
                  state_d   = ST_RECV;
               end else if (ctrl == CTRL_TAIL) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   assign fsm_state = state_q;
   assign v_msg_out = (state_q == ST_FULL);
   assign err_out   = err_q;

   download_datapath #(
      .MAX_FLITS (MAX_FLITS)
   ) u_datapath (
      .clk          (clk),
      .rst          (rst),
      .load_head    (load_head),
      .store_flit   (store_flit),
      .flit_in      (flit_in),
      .cnt_full     (cnt_full),
      .msg_head     (msg_head),
      .msg_addrhi   (msg_addrhi),
      .msg_addrlo   (msg_addrlo),
      .msg_data     (msg_data),
      .msg_flit_cnt (msg_flit_cnt)
   );

endmodule : m_req_download

// File: tb/tb_m_req_download.sv
// ---------------------------------------------------------------------------
// tb_m_req_download
// Directed self-checking bench for m_req_download. Inputs change 1 ns after
// a rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_m_req_download;

   logic          clk = 1'b0;
   logic          rst;
   logic          v_flit_in;
   logic [15:0]   flit_in;
   logic [1:0]    ctrl_in;
   logic          rdy_out;
   logic          msg_rd_in;
   logic          v_msg_out;
   logic [15:0]   msg_head;
   logic [15:0]   msg_addrhi;
   logic [15:0]   msg_addrlo;
   logic [127:0]  msg_data;
   logic [3:0]    msg_flit_cnt;
   logic [1:0]    fsm_state;
   logic          err_out;

   int checks   = 0;
   int failures = 0;

   localparam logic [1:0] C_NONE = 2'b00, C_HEAD = 2'b01, C_BODY = 2'b10, C_TAIL = 2'b11;

   always #5 clk = ~clk;

   m_req_download #(.MAX_FLITS(11)) dut (
      .clk          (clk),
      .rst          (rst),
      .v_flit_in    (v_flit_in),
      .flit_in      (flit_in),
      .ctrl_in      (ctrl_in),
      .rdy_out      (rdy_out),
      .msg_rd_in    (msg_rd_in),
      .v_msg_out    (v_msg_out),
      .msg_head     (msg_head),
      .msg_addrhi   (msg_addrhi),
      .msg_addrlo   (msg_addrlo),
      .msg_data     (msg_data),
      .msg_flit_cnt (msg_flit_cnt),
      .fsm_state    (fsm_state),
      .err_out      (err_out)
   );

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one flit for one clock edge, then return 1 ns after that edge.
   task automatic send(input logic [1:0] c, input logic [15:0] f);
      v_flit_in = 1'b1;
      ctrl_in   = c;
      flit_in   = f;
      @(posedge clk);
      #1;
      v_flit_in = 1'b0;
      ctrl_in   = C_NONE;
      flit_in   = '0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic read_msg();
      msg_rd_in = 1'b1;
      @(posedge clk);
      #1;
      msg_rd_in = 1'b0;
   endtask

   logic [127:0] data_exp;

   initial begin
      rst       = 1'b0;
      v_flit_in = 1'b0;
      flit_in   = '0;
      ctrl_in   = C_NONE;
      msg_rd_in = 1'b0;

      // Reset state
      #12;
      check("rst_state", fsm_state, 2'b00);
      check("rst_vmsg", v_msg_out, 1'b0);
      check("rst_rdy", rdy_out, 1'b1);
      check("rst_err", err_out, 1'b0);
      check("rst_cnt", msg_flit_cnt, 4'd0);
      check("rst_data", msg_data, 128'd0);
      rst = 1'b1;
      idle_cycle();

      // Three-flit message: head, addrhi, tail
      send(C_HEAD, 16'h1234);
      check("m3_state_recv", fsm_state, 2'b01);
      check("m3_cnt1", msg_flit_cnt, 4'd1);
      send(C_BODY, 16'hAAAA);
      check("m3_vmsg_before_tail", v_msg_out, 1'b0);
      send(C_TAIL, 16'h5555);
      check("m3_vmsg", v_msg_out, 1'b1);
      check("m3_state_full", fsm_state, 2'b10);
      check("m3_rdy_full", rdy_out, 1'b0);
      check("m3_cnt", msg_flit_cnt, 4'd3);
      check("m3_head", msg_head, 16'h1234);
      check("m3_addrhi", msg_addrhi, 16'hAAAA);
      check("m3_addrlo", msg_addrlo, 16'h5555);
      check("m3_data", msg_data, 128'd0);
      read_msg();
      check("m3_read_state", fsm_state, 2'b00);
      check("m3_read_vmsg", v_msg_out, 1'b0);

      // Full 11-flit message with data 1..8
      send(C_HEAD, 16'hC000);
      send(C_BODY, 16'h0100);
      send(C_BODY, 16'h0200);
      for (int k = 1; k <= 7; k++) send(C_BODY, 16'(k));
      send(C_TAIL, 16'h0008);
      data_exp = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
      check("m11_vmsg", v_msg_out, 1'b1);
      check("m11_cnt", msg_flit_cnt, 4'd11);
      check("m11_data", msg_data, data_exp);
      check("m11_head", msg_head, 16'hC000);
      check("m11_addrlo", msg_addrlo, 16'h0200);
      // Hold unread for 5 cycles while a flit is offered; it must be refused.
      for (int i = 0; i < 5; i++) begin
         v_flit_in = 1'b1;
         ctrl_in   = C_HEAD;
         flit_in   = 16'hDEAD;
         idle_cycle();
         check("m11_hold_rdy", rdy_out, 1'b0);
         check("m11_hold_vmsg", v_msg_out, 1'b1);
         check("m11_hold_data", msg_data, data_exp);
         check("m11_hold_head", msg_head, 16'hC000);
      end
      v_flit_in = 1'b0;
      ctrl_in   = C_NONE;
      flit_in   = '0;
      read_msg();
      check("m11_read_state", fsm_state, 2'b00);
      check("m11_keep_cnt", msg_flit_cnt, 4'd11);

      // Valid with ctrl NONE in IDLE is ignored
      send(C_NONE, 16'hFFFF);
      check("none_state", fsm_state, 2'b00);
      check("none_err", err_out, 1'b0);

      // Overlong message: 12th non-head flit
      send(C_HEAD, 16'hB000);
      check("ovf_clear_data", msg_data, 128'd0);
      for (int k = 1; k <= 10; k++) send(C_BODY, 16'h0100 + 16'(k));
      check("ovf_cnt11", msg_flit_cnt, 4'd11);
      check("ovf_state_recv", fsm_state, 2'b01);
      send(C_BODY, 16'hEEEE);
      check("ovf_err", err_out, 1'b1);
      check("ovf_state_drop", fsm_state, 2'b11);
      check("ovf_cnt_kept", msg_flit_cnt, 4'd11);
      send(C_BODY, 16'hEEEF);
      check("drop_err_clear", err_out, 1'b0);
      check("drop_state", fsm_state, 2'b11);
      check("drop_vmsg", v_msg_out, 1'b0);
      send(C_TAIL, 16'hEEF0);
      check("drop_tail_state", fsm_state, 2'b00);
      check("drop_tail_vmsg", v_msg_out, 1'b0);
      idle_cycle();
      check("drop_after_vmsg", v_msg_out, 1'b0);

      // Body in IDLE
      send(C_BODY, 16'h7777);
      check("idle_body_err", err_out, 1'b1);
      check("idle_body_state", fsm_state, 2'b00);
      idle_cycle();
      check("idle_body_err_pulse", err_out, 1'b0);

      // Head during RECV restarts; then minimum two-flit completion
      send(C_HEAD, 16'h1111);
      send(C_BODY, 16'h2222);
      send(C_HEAD, 16'h3333);
      check("rehead_err", err_out, 1'b1);
      check("rehead_cnt", msg_flit_cnt, 4'd1);
      check("rehead_head", msg_head, 16'h3333);
      check("rehead_addrhi_cleared", msg_addrhi, 16'h0000);
      check("rehead_state", fsm_state, 2'b01);
      send(C_TAIL, 16'h4444);
      check("min_err_clear", err_out, 1'b0);
      check("min_vmsg", v_msg_out, 1'b1);
      check("min_cnt", msg_flit_cnt, 4'd2);
      check("min_addrhi", msg_addrhi, 16'h4444);
      read_msg();
      check("min_read_state", fsm_state, 2'b00);

      // Asynchronous reset mid-message
      send(C_HEAD, 16'h9999);
      send(C_BODY, 16'h8888);
      #3;
      rst = 1'b0;
      #1;
      check("arst_state", fsm_state, 2'b00);
      check("arst_vmsg", v_msg_out, 1'b0);
      check("arst_rdy", rdy_out, 1'b1);
      check("arst_cnt", msg_flit_cnt, 4'd0);
      check("arst_head", msg_head, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      send(C_TAIL, 16'h6666);
      check("post_rst_tail_err", err_out, 1'b1);
      check("post_rst_tail_state", fsm_state, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_m_req_download
